// File: rtl/game_pkg.sv
// game_pkg: sequencer state encoding and screen/score constants shared with the pipe and top level
package game_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, OVER} seq_state_t;
  localparam logic [9:0] DEF_LAST_X = 10'd639;
  localparam logic [8:0] DEF_LAST_Y = 9'd479;
  localparam logic [7:0] BCD_MAX = 8'h99;
endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: launch/done/score handshake between the sequencer and the pipe renderer
interface pipe_sequencer_if;
  logic updatepipe;
  logic pipe_reset;
  logic pipefinish;
  logic addscore;
  modport master (output updatepipe, pipe_reset, input pipefinish, addscore);
  modport slave (input updatepipe, pipe_reset, output pipefinish, addscore);
endinterface

// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD counter saturating at 99, clr wins over inc; nxt exposes the next value
module bcd_counter2 import game_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q,
  output logic [7:0] nxt
);
  always_comb nxt = clr ? 8'h00 :
                    (!inc || q == BCD_MAX) ? q :
                    (q[3:0] == 4'd9) ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 8'h00;
    else q <= nxt;
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: launches pipe passes, spaces them by GAP_FRAMES frames, keeps score/high score,
// and ends the round on collision
module pipe_sequencer import game_pkg::*; #(
  parameter int         GAP_FRAMES = 30,
  parameter logic [9:0] LAST_X     = DEF_LAST_X,
  parameter logic [8:0] LAST_Y     = DEF_LAST_Y
) (
  input  logic               clk,
  input  logic               resetGame_n,
  input  logic               start,
  input  logic               collision,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  pipe_sequencer_if.master   p,
  output logic [7:0]         score,
  output logic [7:0]         hiscore,
  output logic               playing,
  output logic               game_over
);
  seq_state_t state, nxt;
  logic start_q, add_q, end_q, pipe_reset_q;
  logic [7:0] gap_cnt, score_nxt;
  logic start_rise, add_rise, at_end, tick, launch;
  assign at_end     = x == LAST_X && y == LAST_Y;
  assign tick       = at_end && !end_q;
  assign start_rise = start && !start_q;
  assign add_rise   = p.addscore && !add_q;
  assign launch     = start_rise && (state == IDLE || state == OVER);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_rise ? ARM : IDLE;
      ARM:     nxt = collision ? OVER : p.pipefinish ? ARM : RUN;
      RUN:     nxt = collision ? OVER : p.pipefinish ? GAP : RUN;
      GAP:     nxt = collision ? OVER : (tick && gap_cnt == 8'd1) ? ARM : GAP;
      OVER:    nxt = start_rise ? ARM : OVER;
      default: nxt = IDLE;
    endcase
  end
  bcd_counter2 u_score (
    .clk(clk), .rst_n(resetGame_n), .clr(launch), .inc(add_rise && state == RUN),
    .q(score), .nxt(score_nxt)
  );
  // hiscore takes score_nxt so a point scored on the collision cycle still counts
  always_ff @(posedge clk or negedge resetGame_n)
    if (!resetGame_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      add_q        <= 1'b0;
      end_q        <= 1'b0;
      pipe_reset_q <= 1'b0;
      gap_cnt      <= 8'd0;
      hiscore      <= 8'h00;
    end else begin
      state        <= nxt;
      start_q      <= start;
      add_q        <= p.addscore;
      end_q        <= at_end;
      pipe_reset_q <= launch;
      if (state == RUN && nxt == GAP) gap_cnt <= 8'(GAP_FRAMES);
      else if (state == GAP && tick) gap_cnt <= gap_cnt - 8'd1;
      if (nxt == OVER && state != OVER && score_nxt > hiscore) hiscore <= score_nxt;
    end
  assign p.updatepipe = state == ARM || state == RUN;
  assign p.pipe_reset = pipe_reset_q;
  assign playing      = state == ARM || state == RUN || state == GAP;
  assign game_over    = state == OVER;
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed scenario tests for pipe_sequencer with GAP_FRAMES=3
module tb_pipe_sequencer;
  import game_pkg::*;
  logic clk = 1'b0;
  logic resetGame_n = 1'b0;
  logic start = 1'b0;
  logic collision = 1'b0;
  logic [9:0] x = 10'd0;
  logic [8:0] y = 9'd0;
  logic [7:0] score, hiscore;
  logic playing, game_over;
  int checks = 0;
  int errors = 0;
  pipe_sequencer_if pif ();
  pipe_sequencer #(.GAP_FRAMES(3)) dut (
    .clk(clk), .resetGame_n(resetGame_n), .start(start), .collision(collision),
    .x(x), .y(y), .p(pif), .score(score), .hiscore(hiscore),
    .playing(playing), .game_over(game_over)
  );
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_add(input int hi);
    pif.addscore = 1'b1;
    step(hi);
    pif.addscore = 1'b0;
    step(2);
  endtask

  task automatic frame_tick();
    x = 10'd639; y = 9'd479;
    step(1);
    x = 10'd0; y = 9'd0;
    step(1);
  endtask

  task automatic launch_round();
    pif.pipefinish = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    pif.pipefinish = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    pif.pipefinish = 1'b1;
    pif.addscore = 1'b0;
    step(3);
    checks++; if (pif.updatepipe !== 1'b0) begin errors++; $display("FAIL reset_updatepipe got %b want 0", pif.updatepipe); end
    checks++; if (pif.pipe_reset !== 1'b0) begin errors++; $display("FAIL reset_pipe_reset got %b want 0", pif.pipe_reset); end
    checks++; if (score !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", score); end
    checks++; if (hiscore !== 8'h00) begin errors++; $display("FAIL reset_hiscore got %h want 00", hiscore); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b want 0", playing); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", game_over); end
    resetGame_n = 1'b1;
    step(2);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL idle_no_start got playing=%b want 0", playing); end
  endtask

  task automatic test_launch();
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (pif.pipe_reset !== 1'b1) begin errors++; $display("FAIL launch_pipe_reset got %b want 1", pif.pipe_reset); end
    checks++; if (pif.updatepipe !== 1'b1) begin errors++; $display("FAIL launch_updatepipe got %b want 1", pif.updatepipe); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL launch_playing got %b want 1", playing); end
    step(1);
    checks++; if (pif.pipe_reset !== 1'b0) begin errors++; $display("FAIL launch_pulse_width got %b want 0", pif.pipe_reset); end
    step(1);
    checks++; if (dut.state !== ARM) begin errors++; $display("FAIL arm_wait got state %0d want %0d", dut.state, ARM); end
    pif.pipefinish = 1'b0;
    step(1);
    checks++; if (dut.state !== RUN) begin errors++; $display("FAIL arm_to_run got state %0d want %0d", dut.state, RUN); end
    checks++; if (pif.updatepipe !== 1'b1) begin errors++; $display("FAIL run_updatepipe got %b want 1", pif.updatepipe); end
    pif.pipefinish = 1'b1;
    step(1);
    checks++; if (pif.updatepipe !== 1'b0) begin errors++; $display("FAIL gap_updatepipe got %b want 0", pif.updatepipe); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL gap_playing got %b want 1", playing); end
  endtask

  task automatic test_gap();
    x = 10'd639; y = 9'd479;
    step(5);
    x = 10'd0; y = 9'd0;
    step(1);
    frame_tick();
    checks++; if (pif.updatepipe !== 1'b0) begin errors++; $display("FAIL gap_two_ticks got updatepipe=%b want 0", pif.updatepipe); end
    checks++; if (dut.state !== GAP) begin errors++; $display("FAIL gap_hold_one_tick got state %0d want %0d", dut.state, GAP); end
    x = 10'd639; y = 9'd479;
    step(1);
    checks++; if (pif.updatepipe !== 1'b1) begin errors++; $display("FAIL gap_third_tick got updatepipe=%b want 1", pif.updatepipe); end
    checks++; if (pif.pipe_reset !== 1'b0) begin errors++; $display("FAIL rearm_no_reset got %b want 0", pif.pipe_reset); end
    x = 10'd0; y = 9'd0;
    step(1);
  endtask

  task automatic test_collision();
    pif.pipefinish = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) pulse_add(1);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL coll_game_over got %b want 1", game_over); end
    checks++; if (pif.updatepipe !== 1'b0) begin errors++; $display("FAIL coll_updatepipe got %b want 0", pif.updatepipe); end
    checks++; if (hiscore !== 8'h05) begin errors++; $display("FAIL coll_hiscore_first got %h want 05", hiscore); end
    launch_round();
    checks++; if (score !== 8'h00) begin errors++; $display("FAIL restart_score_clear got %h want 00", score); end
    for (int i = 0; i < 6; i++) pulse_add(1);
    pif.addscore = 1'b1;
    collision = 1'b1;
    step(1);
    pif.addscore = 1'b0;
    collision = 1'b0;
    checks++; if (score !== 8'h07) begin errors++; $display("FAIL coll_same_cycle_score got %h want 07", score); end
    checks++; if (hiscore !== 8'h07) begin errors++; $display("FAIL coll_hiscore_update got %h want 07", hiscore); end
    step(1);
    pulse_add(3);
    checks++; if (score !== 8'h07) begin errors++; $display("FAIL over_score_frozen got %h want 07", score); end
    launch_round();
    for (int i = 0; i < 3; i++) pulse_add(1);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    checks++; if (score !== 8'h03) begin errors++; $display("FAIL low_round_score got %h want 03", score); end
    checks++; if (hiscore !== 8'h07) begin errors++; $display("FAIL hiscore_kept got %h want 07", hiscore); end
  endtask

  task automatic test_restart();
    launch_round();
    start = 1'b1;
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    step(3);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL held_start_stays_over got %b want 1", game_over); end
    start = 1'b0;
    step(1);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL release_stays_over got %b want 1", game_over); end
    pif.pipefinish = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (pif.pipe_reset !== 1'b1) begin errors++; $display("FAIL restart_pipe_reset got %b want 1", pif.pipe_reset); end
    checks++; if (score !== 8'h00) begin errors++; $display("FAIL restart_score got %h want 00", score); end
    checks++; if (game_over !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL restart_state got game_over=%b playing=%b want 0 1", game_over, playing); end
  endtask

  task automatic test_score();
    pif.pipefinish = 1'b0;
    step(1);
    pif.addscore = 1'b1;
    step(1);
    checks++; if (score !== 8'h01) begin errors++; $display("FAIL score_latency got %h want 01", score); end
    step(999);
    pif.addscore = 1'b0;
    step(2);
    for (int i = 0; i < 11; i++) pulse_add(1000);
    checks++; if (score !== 8'h12) begin errors++; $display("FAIL score_twelve got %h want 12", score); end
    pif.pipefinish = 1'b1;
    step(1);
    checks++; if (pif.updatepipe !== 1'b0) begin errors++; $display("FAIL score_gap_entry got %b want 0", pif.updatepipe); end
    pulse_add(2);
    checks++; if (score !== 8'h12) begin errors++; $display("FAIL score_in_gap got %h want 12", score); end
    for (int i = 0; i < 3; i++) frame_tick();
    checks++; if (dut.state !== ARM) begin errors++; $display("FAIL score_rearm got state %0d want %0d", dut.state, ARM); end
    pif.pipefinish = 1'b0;
    step(1);
    for (int i = 0; i < 86; i++) pulse_add(1);
    checks++; if (score !== 8'h98) begin errors++; $display("FAIL score_98 got %h want 98", score); end
    for (int i = 0; i < 3; i++) pulse_add(1);
    checks++; if (score !== 8'h99) begin errors++; $display("FAIL score_saturate got %h want 99", score); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 resetGame_n = 1'b0;
    #1;
    checks++; if (pif.updatepipe !== 1'b0 || pif.pipe_reset !== 1'b0) begin errors++; $display("FAIL areset_pipe got updatepipe=%b pipe_reset=%b want 0 0", pif.updatepipe, pif.pipe_reset); end
    checks++; if (score !== 8'h00) begin errors++; $display("FAIL areset_score got %h want 00", score); end
    checks++; if (hiscore !== 8'h00) begin errors++; $display("FAIL areset_hiscore got %h want 00", hiscore); end
    checks++; if (playing !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL areset_flags got playing=%b game_over=%b want 0 0", playing, game_over); end
    step(2);
    resetGame_n = 1'b1;
    step(2);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL areset_idle got state %0d want %0d", dut.state, IDLE); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_gap();
    test_collision();
    test_restart();
    test_score();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Game-level controller that sequences the `pipe` obstacle renderer. It launches each pipe pass with the `updatepipe`/`pipefinish` handshake and spaces passes by a programmable number of video frames. It also counts score from the pipe's `addscore` strobe, keeps a high score, and ends the round on collision. It sits between the top-level key/collision logic and the `pipe` instance, and it owns the pipe's reset.

## Interface
Parameters:
- `GAP_FRAMES`, 30: frames between the end of one pipe pass and the next launch (1–255).
- `LAST_X`, 10'd639: final visible column; frame tick is detected here.
- `LAST_Y`, 9'd479: final visible row.

Ports:
- `clk`  in  1  system clock.
- `resetGame_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  player start/restart key, level, synchronous to `clk`.
- `collision`  in  1  bird-hit flag, level.
- `x`  in  10  current VGA column.
- `y`  in  9  current VGA row.
- `pipefinish`  in  1  from `pipe`: high when the pipe is idle or done.
- `addscore`  in  1  from `pipe`: high while the pipe is at the scoring column; may last many cycles.
- `updatepipe`  out  1  to `pipe`: launch request.
- `pipe_reset`  out  1  to `pipe.resetGame`: active-high, one-cycle pulse.
- `score`  out  8  two BCD digits {tens, ones}.
- `hiscore`  out  8  two BCD digits.
- `playing`  out  1  high in ARM, RUN and GAP.
- `game_over`  out  1  high in OVER.

## Operation
- States: IDLE, ARM, RUN, GAP, OVER. Reset enters IDLE.
- **IDLE**: on a rising edge of `start` → ARM. That same edge pulses `pipe_reset` for 1 cycle and clears `score` to 8'h00.
- **ARM**: `updatepipe`=1. Wait for `pipefinish`=0, meaning the pipe has left idle, then → RUN. The wait is required because `pipefinish` is already 1 while the pipe is idle.
- **RUN**: `updatepipe`=1. On `pipefinish`=1 (pipe done) → GAP. Dropping `updatepipe` there returns the pipe to idle.
- **GAP**: `updatepipe`=0. An 8-bit frame counter loads `GAP_FRAMES` on entry and decrements on each frame tick. When it reaches 0 → ARM.
- **OVER**: `updatepipe`=0, `score` frozen. On a rising edge of `start` → ARM with the same `pipe_reset` pulse and score clear as from IDLE.
- **Collision**: `collision`=1 in ARM, RUN or GAP → OVER on the next edge. Collision takes priority over every other transition in the same cycle. It is ignored in IDLE and OVER.
- **Frame tick**: a 1-cycle pulse on the rising edge of (`x`==`LAST_X` && `y`==`LAST_Y`). Because this is edge-detected, the tick fires once per frame even if x/y hold for several clocks.
- **Score**: +1 on each rising edge of `addscore` seen while in RUN.
  - BCD arithmetic: ones 9→0 carries into tens.
  - Saturates at 8'h99.
  - `addscore` held high counts once.
- **High score**: on the OVER-entry edge, `hiscore` ← `score` if `score` > `hiscore`. Compare as an 8-bit unsigned value, which is valid for BCD ordering. Only reset clears `hiscore`.
- **Start edge detect**: a register holds the previous `start`. A `start` held high across entry to OVER does not restart the game; it must fall and rise again.

## Timing
- Reset (async assert, sync release) leaves all outputs 0: `updatepipe`, `pipe_reset`, `score`=8'h00, `hiscore`=8'h00, `playing`, `game_over`. State is IDLE, and the edge-detect registers clear.
- All outputs are registered Moore decodes of state or registers; nothing is combinational from inputs.
- `updatepipe` rises on the first cycle in ARM and falls on the first cycle in GAP or OVER.
- `pipe_reset` is high exactly on the first cycle of ARM after a start. The ARM→RUN check is therefore unaffected by the pipe's start→idle state, because `pipefinish` is 1 there.
- The score increments 1 cycle after the `addscore` rising edge.
- GAP lasts exactly `GAP_FRAMES` frame ticks.
- If a tick and a collision occur together in GAP → OVER.
- If `addscore` rises in the same cycle as RUN→GAP → count it.
- If it rises in the same cycle as a collision in RUN → count it, and `hiscore` uses the updated score.
- Reset mid-round: immediate IDLE, and `hiscore` is lost.

## Structure
- `game_pkg`: state enum `seq_state_t`, plus `LAST_X`/`LAST_Y` defaults and the BCD max constant 8'h99, shared with `pipe` and the top level.
- One sub-module: `bcd_counter2` (two-digit saturating BCD counter with `clr` and `inc`), used for `score`.
- The frame-tick and start/addscore edge detectors stay inline.

## Test plan
- **Launch handshake**: reset, pulse `start`, model `pipefinish` 1→0 at +3 cycles → `pipe_reset` 1 cycle, `updatepipe`=1 from ARM entry, state RUN after the fall. Then `pipefinish`=1 → `updatepipe`=0 next cycle.
- **Gap**: `GAP_FRAMES`=3, drive x/y sweeps → ARM re-entered on the 3rd frame tick. x=639/y=479 held 5 cycles gives only one tick.
- **Score**: 12 `addscore` pulses of 1000 cycles each in RUN → `score`=8'h12. From 8'h98, three pulses → 8'h99 (saturated). A pulse in GAP → no change.
- **Collision**: collision in RUN with `score`=8'h07 and `hiscore`=8'h05 → OVER, `updatepipe`=0, `hiscore`=8'h07. Next round scoring 8'h03 → `hiscore` stays 8'h07.
- **Restart**: `start` held high through OVER entry → stays OVER. Release then press → ARM, `score`=8'h00, `pipe_reset` pulse.
- **Async reset mid-RUN**: assert `resetGame_n`=0 between clock edges → outputs 0 immediately, `hiscore`=8'h00.
